uart_sync_fifo: RTL and testbench



---
 rtl/uart_sync_fifo.sv | 64 ++++++
 tb/tb_uart_sync_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO of 2^ADDR_WIDTH words with registered read data and
// full/empty flags decoded from an occupancy counter; overflow/underflow requests are dropped.
module uart_sync_fifo #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_req,
   input  logic                  read_req,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   empty
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  write_ok;
   logic                  read_ok;

   // Handshake: a request is taken on the rising edge when its flag (as seen
   // before that edge) allows it; otherwise it is discarded with no side effect.
   assign write_ok = write_req & ~full;
   assign read_ok  = read_req & ~empty;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

   // Storage has no reset; stale words are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (write_ok) begin
         mem[wptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         if (write_ok) begin
            wptr <= wptr + 1'b1;
         end
         if (read_ok) begin
            data_out <= mem[rptr];
            rptr     <= rptr + 1'b1;
         end
         case ({write_ok, read_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed plus random bench for uart_sync_fifo: a queue model predicts data_out
// and the flags after every clock edge.
module tb_uart_sync_fifo;

   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          write_req = 1'b0;
   logic          read_req = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          full;
   logic          empty;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_dout = '0;
   int            n_checks = 0;
   int            n_errors = 0;

   uart_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .write_req (write_req),
      .read_req  (read_req),
      .data_in   (data_in),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock: drive at the falling edge, update the model for the rising
   // edge, then compare just after that edge.
   task automatic cycle(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] din,
                        input string tag);
      bit wr_ok;
      bit rd_ok;
      @(negedge clk);
      reset     = rst;
      write_req = wr;
      read_req  = rd;
      data_in   = din;
      wr_ok = wr && (exp_q.size() < DEPTH);
      rd_ok = rd && (exp_q.size() > 0);
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         exp_dout = '0;
      end else begin
         if (rd_ok) exp_dout = exp_q.pop_front();
         if (wr_ok) exp_q.push_back(din);
      end
      check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
      check({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
      check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
      reset     = 1'b0;
      write_req = 1'b0;
      read_req  = 1'b0;
   endtask

   initial begin
      // Reset held for two cycles, then idle.
      cycle(1'b1, 1'b0, 1'b0, 8'h00, "reset0");
      cycle(1'b1, 1'b0, 1'b0, 8'h00, "reset1");
      cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle");
      check("reset.const_empty", 32'(empty), 32'd1);
      check("reset.const_dout", 32'(data_out), 32'h00);

      // Fill to full.
      cycle(1'b0, 1'b1, 1'b0, 8'hA5, "fill0");
      check("fill0.not_empty", 32'(empty), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 8'h5A, "fill1");
      cycle(1'b0, 1'b1, 1'b0, 8'hFF, "fill2");
      cycle(1'b0, 1'b1, 1'b0, 8'h00, "fill3");
      check("fill3.full", 32'(full), 32'd1);

      // Overflow write is dropped.
      cycle(1'b0, 1'b1, 1'b0, 8'h11, "overflow");

      // Drain three in order.
      cycle(1'b0, 1'b0, 1'b1, 8'h00, "pop0");
      check("pop0.const", 32'(data_out), 32'hA5);
      check("pop0.not_full", 32'(full), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 8'h00, "pop1");
      check("pop1.const", 32'(data_out), 32'h5A);
      cycle(1'b0, 1'b0, 1'b1, 8'h00, "pop2");
      check("pop2.const", 32'(data_out), 32'hFF);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, "hold");

      // Simultaneous write/read with one entry, across the pointer wrap.
      cycle(1'b0, 1'b1, 1'b1, 8'hCC, "simul");
      check("simul.const", 32'(data_out), 32'h00);
      cycle(1'b0, 1'b0, 1'b1, 8'h00, "after_simul");
      check("after_simul.const", 32'(data_out), 32'hCC);
      check("after_simul.empty", 32'(empty), 32'd1);

      // Underflow read is dropped, then a round trip.
      cycle(1'b0, 1'b0, 1'b1, 8'h00, "underflow");
      check("underflow.hold", 32'(data_out), 32'hCC);
      cycle(1'b0, 1'b1, 1'b1, 8'h3C, "empty_both");
      check("empty_both.no_bypass", 32'(data_out), 32'hCC);
      cycle(1'b0, 1'b0, 1'b1, 8'h00, "roundtrip");
      check("roundtrip.const", 32'(data_out), 32'h3C);

      // Full with both requests: read taken, write dropped.
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), "refill");
      cycle(1'b0, 1'b1, 1'b1, 8'h99, "full_both");
      check("full_both.const", 32'(data_out), 32'h40);

      // Random traffic.
      for (int i = 0; i < 60; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rand");
      end

      // Reset mid-operation overrides a simultaneous write.
      cycle(1'b0, 1'b1, 1'b0, 8'h77, "pre_reset");
      cycle(1'b1, 1'b1, 1'b1, 8'h88, "mid_reset");
      check("mid_reset.empty", 32'(empty), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 8'h5B, "post_reset_wr");
      cycle(1'b0, 1'b0, 1'b1, 8'h00, "post_reset_rd");
      check("post_reset_rd.const", 32'(data_out), 32'h5B);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
